// File: rtl/lighthouse_pkg.sv
`default_nettype none
// ============================================================================
// lighthouse_pkg : record type, decoder state encoding and timing defaults
// Revision: 1.0
// ============================================================================
package lighthouse_pkg;

    localparam int          c_tb_w        = 20;
    localparam int          c_width_w     = 13;
    localparam logic [12:0] c_width_max   = 13'h1FFF;

    // Sync code bit positions; bit 1 carries the data stream and is not used here.
    localparam logic [1:0]  c_code_axis   = 2'd0;
    localparam logic [1:0]  c_code_skip   = 2'd2;

    localparam int c_def_sync_base   = 2865;
    localparam int c_def_sync_step   = 521;
    localparam int c_def_sweep_max_w = 1500;
    localparam int c_def_pair_gap    = 25000;
    localparam int c_def_timeout     = 450000;

    typedef struct packed {
        logic [19:0] sweep;
        logic [12:0] width;
        logic        axis;
        logic        station;
        logic [3:0]  sensor;
    } sweep_record_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_CLASSIFY = 2'd2
    } dec_state_t;

    // Number of bin thresholds (base + k*step, k = 1..7) reached by a sync width.
    function automatic logic [2:0] sync_code(input logic [12:0] width,
                                             input int base, input int step);
        logic [2:0] code;
        code = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            if ({19'd0, width} >= 32'(base + k * step)) begin
                code = code + 3'd1;
            end
        end
        return code;
    endfunction

    function automatic logic sync_code_bit(input logic [12:0] width, input int base,
                                           input int step, input logic [1:0] idx);
        logic [2:0] code;
        code = sync_code(width, base, step);
        return code[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lighthouse_record_fifo.sv
`default_nettype none
// ============================================================================
// lighthouse_record_fifo : first-word-fall-through record queue, valid/ready out
// Revision: 1.0
// ============================================================================
module lighthouse_record_fifo
    import lighthouse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  sweep_record_t push_data,
    output logic          dropped,
    output logic          out_valid,
    input  logic          out_ready,
    output sweep_record_t out_data
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

    sweep_record_t     r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_count == c_full);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push_ok = push && (!w_full || w_pop);
    assign dropped   = push && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{c_aw{1'b0}}, w_push_ok} - {{c_aw{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/lighthouse_pulse_decoder.sv
`default_nettype none
// ============================================================================
// lighthouse_pulse_decoder : per-photodiode sync/sweep decoder with record queue
// Revision: 1.0
// ============================================================================
module lighthouse_pulse_decoder
    import lighthouse_pkg::*;
#(
    parameter logic [3:0] SENSOR_ID   = 4'd0,
    parameter int         FILTER_LEN  = 4,
    parameter int         SYNC_BASE   = c_def_sync_base,
    parameter int         SYNC_STEP   = c_def_sync_step,
    parameter int         SWEEP_MAX_W = c_def_sweep_max_w,
    parameter int         PAIR_GAP    = c_def_pair_gap,
    parameter int         TIMEOUT     = c_def_timeout,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sensor_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_sweep,
    output logic [12:0] out_width,
    output logic        out_axis,
    output logic        out_station,
    output logic [3:0]  out_sensor,
    output logic        locked,
    output logic [7:0]  overflow_count
);

    localparam logic [3:0]          c_filt_last = 4'(FILTER_LEN - 1);
    localparam logic [c_width_w-1:0] c_sync_base = c_width_w'(SYNC_BASE);
    localparam logic [c_width_w-1:0] c_sweep_max = c_width_w'(SWEEP_MAX_W);
    localparam logic [c_tb_w-1:0]    c_pair_gap  = c_tb_w'(PAIR_GAP);
    localparam logic [c_tb_w-1:0]    c_timeout   = c_tb_w'(TIMEOUT);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_filt;
    logic                 r_filt_d;
    logic [3:0]           r_filt_cnt;
    logic                 r_armed;
    logic [c_tb_w-1:0]    r_tb;
    logic [c_tb_w-1:0]    r_rise_tb;
    logic [c_tb_w-1:0]    r_last_sync;
    logic [c_tb_w-1:0]    r_active_rise;
    logic [c_width_w-1:0] r_width;
    logic                 r_active_axis;
    logic                 r_active_station;
    logic                 r_locked;
    logic [7:0]           r_overflow;
    dec_state_t           r_state;
    dec_state_t           w_next;

    logic          w_rise;
    logic          w_is_sync;
    logic          w_is_sweep;
    logic          w_pair;
    logic          w_axis;
    logic          w_skip;
    logic          w_dropped;
    sweep_record_t w_push_rec;
    sweep_record_t w_out_rec;

    // Synchroniser and filter start "high" so a pulse in progress at reset is
    // never seen as a rising edge; arming waits for a confirmed low level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync1  <= sensor_i;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            r_armed  <= r_armed | ~r_filt;
            if (r_sync2 != r_filt) begin
                if (r_filt_cnt == c_filt_last) begin
                    r_filt     <= r_sync2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 4'd1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_rise = r_filt && !r_filt_d && r_armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (r_width == c_width_max) begin
                    w_next = ST_IDLE;
                end else if (!r_filt) begin
                    w_next = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    assign w_is_sync  = (r_state == ST_CLASSIFY) && (r_width >= c_sync_base)
                        && (r_width != c_width_max);
    assign w_is_sweep = (r_state == ST_CLASSIFY) && (r_width < c_sweep_max) && r_locked;
    assign w_axis     = sync_code_bit(r_width, SYNC_BASE, SYNC_STEP, c_code_axis);
    assign w_skip     = sync_code_bit(r_width, SYNC_BASE, SYNC_STEP, c_code_skip);
    assign w_pair     = (r_rise_tb - r_last_sync) < c_pair_gap;

    always_comb begin
        w_push_rec         = '0;
        w_push_rec.sweep   = r_rise_tb - r_active_rise;
        w_push_rec.width   = r_width;
        w_push_rec.axis    = r_active_axis;
        w_push_rec.station = r_active_station;
        w_push_rec.sensor  = SENSOR_ID;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tb             <= '0;
            r_rise_tb        <= '0;
            r_width          <= '0;
            r_last_sync      <= '0;
            r_active_rise    <= '0;
            r_active_axis    <= 1'b0;
            r_active_station <= 1'b0;
            r_locked         <= 1'b0;
            r_overflow       <= '0;
        end else begin
            r_tb <= r_tb + 20'd1;
            if (r_state == ST_IDLE && w_rise) begin
                r_rise_tb <= r_tb;
                r_width   <= '0;
            end else if (r_state == ST_HIGH && r_width != c_width_max) begin
                r_width <= r_width + 13'd1;
            end
            if (w_is_sync) begin
                r_last_sync <= r_rise_tb;
                if (!w_skip) begin
                    r_active_rise    <= r_rise_tb;
                    r_active_axis    <= w_axis;
                    r_active_station <= w_pair;
                end
            end
            // A fresh active sync wins over expiry of the previous one.
            if (w_is_sync && !w_skip) begin
                r_locked <= 1'b1;
            end else if ((r_tb - r_active_rise) >= c_timeout) begin
                r_locked <= 1'b0;
            end
            if (w_dropped && r_overflow != 8'hFF) begin
                r_overflow <= r_overflow + 8'd1;
            end
        end
    end

    lighthouse_record_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_is_sweep),
        .push_data (w_push_rec),
        .dropped   (w_dropped),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_rec)
    );

    assign out_sweep      = w_out_rec.sweep;
    assign out_width      = w_out_rec.width;
    assign out_axis       = w_out_rec.axis;
    assign out_station    = w_out_rec.station;
    assign out_sensor     = w_out_rec.sensor;
    assign locked         = r_locked;
    assign overflow_count = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lighthouse_pulse_decoder.sv
`default_nettype none
// ============================================================================
// tb_lighthouse_pulse_decoder : directed scoreboard bench for the pulse decoder
// Revision: 1.0
// ============================================================================
module tb_lighthouse_pulse_decoder;
    import lighthouse_pkg::*;

    localparam logic [3:0] TB_SENSOR  = 4'd9;
    localparam int         FILTER_LEN = 4;
    localparam int         PAIR_GAP   = 8000;
    localparam int         TIMEOUT    = 15000;
    localparam int         WATCHDOG   = 150000;

    logic        clock = 1'b0;
    logic        reset;
    logic        sensor_i;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sweep;
    logic [12:0] out_width;
    logic        out_axis;
    logic        out_station;
    logic [3:0]  out_sensor;
    logic        locked;
    logic [7:0]  overflow_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    sweep_record_t exp_q[$];

    lighthouse_pulse_decoder #(
        .SENSOR_ID   (TB_SENSOR),
        .FILTER_LEN  (FILTER_LEN),
        .SYNC_BASE   (2865),
        .SYNC_STEP   (521),
        .SWEEP_MAX_W (1500),
        .PAIR_GAP    (PAIR_GAP),
        .TIMEOUT     (TIMEOUT),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sensor_i       (sensor_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sweep      (out_sweep),
        .out_width      (out_width),
        .out_axis       (out_axis),
        .out_station    (out_station),
        .out_sensor     (out_sensor),
        .locked         (locked),
        .overflow_count (overflow_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Raw high for w sampling edges; rise is the cycle count when it was driven.
    task automatic pulse(input int w, output int rise);
        @(posedge clock);
        #1;
        rise     = cyc;
        sensor_i = 1'b1;
        repeat (w) @(posedge clock);
        #1;
        sensor_i = 1'b0;
    endtask

    task automatic expect_rec(input int sweep, input int w, input logic ax, input logic st);
        sweep_record_t e;
        e.sweep   = 20'(sweep);
        e.width   = 13'(w);
        e.axis    = ax;
        e.station = st;
        e.sensor  = TB_SENSOR;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            chk("record_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sweep_record_t e;
                e = exp_q.pop_front();
                chk("rec_sweep",   32'(out_sweep),   32'(e.sweep));
                chk("rec_width",   32'(out_width),   32'(e.width));
                chk("rec_axis",    32'(out_axis),    32'(e.axis));
                chk("rec_station", 32'(out_station), 32'(e.station));
                chk("rec_sensor",  32'(out_sensor),  32'(e.sensor));
            end
        end
    end

    initial begin
        repeat (WATCHDOG) @(posedge clock);
        $display("FAIL watchdog cycles=%0d limit=%0d", cyc, WATCHDOG);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int k;
        int w;
        reset     = 1'b1;
        sensor_i  = 1'b1;
        out_ready = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        chk("rst_valid",    32'(out_valid),      32'd0);
        chk("rst_sweep",    32'(out_sweep),      32'd0);
        chk("rst_width",    32'(out_width),      32'd0);
        chk("rst_axis",     32'(out_axis),       32'd0);
        chk("rst_station",  32'(out_station),    32'd0);
        chk("rst_sensor",   32'(out_sensor),     32'd0);
        chk("rst_locked",   32'(locked),         32'd0);
        chk("rst_overflow", 32'(overflow_count), 32'd0);
        reset = 1'b0;

        // Pulse already high at reset must not count, even though it is sync-long.
        idle(3300);
        sensor_i = 1'b0;
        idle(6000);
        chk("arm_locked", 32'(locked),    32'd0);
        chk("arm_valid",  32'(out_valid), 32'd0);

        // Single code-0 sync then a sweep.
        pulse(3200, s);
        idle(20);
        chk("sync0_locked", 32'(locked), 32'd1);
        wait_until(s + 7000 - 1);
        pulse(200, w);
        expect_rec(w - s, 200, 1'b0, 1'b0);
        idle(2000);

        // Active sync first, skip sync (code 4) second: station 0.
        pulse(3200, s);
        wait_until(s + 5000 - 1);
        pulse(5200, k);
        wait_until(s + 11000 - 1);
        pulse(300, w);
        expect_rec(w - s, 300, 1'b0, 1'b0);
        idle(2500);

        // Skip sync first, active sync second: station 1.
        pulse(5200, k);
        wait_until(k + 6000 - 1);
        pulse(3200, s);
        wait_until(s + 4000 - 1);
        pulse(150, w);
        expect_rec(w - s, 150, 1'b0, 1'b1);
        idle(4500);

        // Code-1 sync sets axis, then lock expires at the timeout boundary.
        pulse(3600, s);
        wait_until(s + 4000 - 1);
        pulse(100, w);
        expect_rec(w - s, 100, 1'b1, 1'b0);
        wait_until(s + TIMEOUT + 2 + FILTER_LEN);
        chk("timeout_before", 32'(locked), 32'd1);
        idle(1);
        chk("timeout_after", 32'(locked), 32'd0);
        pulse(100, w);
        idle(50);
        chk("late_sweep_q", 32'(exp_q.size()), 32'd0);

        // Glitch and stuck-high pulse while locked produce nothing.
        pulse(3200, s);
        idle(300);
        pulse(3, w);
        idle(300);
        pulse(9000, w);
        idle(50);
        chk("sat_q", 32'(exp_q.size()), 32'd0);
        chk("sat_locked", 32'(locked), 32'd1);

        // Six sweeps into a blocked queue: four kept, two counted as dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(60, w);
            if (i < 4) begin
                expect_rec(w - s, 60, 1'b0, 1'b0);
            end
            idle(60);
        end
        idle(20);
        chk("ovf_count", 32'(overflow_count), 32'd2);
        chk("ovf_valid", 32'(out_valid),      32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("drain_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clock);
        chk("drain_empty", 32'(out_valid),      32'd0);
        chk("drain_q",     32'(exp_q.size()),   32'd0);
        chk("final_ovf",   32'(overflow_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
